kbd_mouse_feeder: RTL and testbench

KBD_MOUSE_FEEDER -- requirements
Module: kbd_mouse_feeder

---
 rtl/kbd_mouse_feeder.sv | 175 +++++++++++++++++
 tb/tb_kbd_mouse_feeder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/kbd_mouse_feeder.sv
// Keyboard/mouse word feeder: queues Amiga keycodes, accumulates mouse
// motion and emits one typed word per level toggle, spaced GAP_CYCLES apart.
// Mouse X/Y words always go out as an unbroken pair.
module kbd_mouse_feeder #(
    parameter int GAP_CYCLES     = 64,  // must be >= 2
    parameter int KEY_FIFO_DEPTH = 8    // power of two, >= 2
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       key_strobe,
    input  logic [7:0] key_code,
    input  logic       mouse_strobe,
    input  logic [7:0] mouse_dx,
    input  logic [7:0] mouse_dy,
    input  logic [2:0] mouse_btn_in,
    output logic       kbd_mouse_level,
    output logic [1:0] kbd_mouse_type,
    output logic [7:0] kbd_mouse_data,
    output logic [2:0] mouse_buttons,
    output logic       key_overflow,
    output logic       busy
);
    localparam int AW = $clog2(KEY_FIFO_DEPTH);
    localparam int CW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {S_IDLE, S_SEND_KEY, S_SEND_X, S_SEND_Y, S_WAIT} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]        mem_q [KEY_FIFO_DEPTH];
    logic [7:0]        mem_d [KEY_FIFO_DEPTH];
    logic [7:0]        acc_x_q, acc_x_d, acc_y_q, acc_y_d, snap_y_q, snap_y_d;
    logic              mouse_pending_q, mouse_pending_d, y_owed_q, y_owed_d;
    logic              level_q, level_d, overflow_q, overflow_d;
    logic [1:0]        type_q, type_d;
    logic [7:0]        data_q, data_d;
    logic [2:0]        buttons_q, buttons_d;

    logic fifo_empty, fifo_full, pop, push, send_x, send_y, wait_done;
    logic [7:0] base_x, base_y;

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic signed [8:0] s;
        s = $signed({a[7], a}) + $signed({b[7], b});
        if (s > 9'sd127)       return 8'h7F;
        else if (s < -9'sd128) return 8'h80;
        else                   return s[7:0];
    endfunction

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign wait_done  = (cnt_q == CW'(GAP_CYCLES - 2));

    // State register plus all datapath flops
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            for (int i = 0; i < KEY_FIFO_DEPTH; i++) mem_q[i] <= '0;
            acc_x_q         <= '0;
            acc_y_q         <= '0;
            snap_y_q        <= '0;
            mouse_pending_q <= 1'b0;
            y_owed_q        <= 1'b0;
            level_q         <= 1'b0;
            type_q          <= '0;
            data_q          <= '0;
            buttons_q       <= '0;
            overflow_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            mem_q           <= mem_d;
            acc_x_q         <= acc_x_d;
            acc_y_q         <= acc_y_d;
            snap_y_q        <= snap_y_d;
            mouse_pending_q <= mouse_pending_d;
            y_owed_q        <= y_owed_d;
            level_q         <= level_d;
            type_q          <= type_d;
            data_q          <= data_d;
            buttons_q       <= buttons_d;
            overflow_q      <= overflow_d;
        end
    end

    // Next state: the last WAIT cycle dispatches directly so back-to-back
    // words stay exactly GAP_CYCLES apart; a pending Y beats queued keys.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty)          state_d = S_SEND_KEY;
                else if (mouse_pending_q) state_d = S_SEND_X;
            end
            S_SEND_KEY, S_SEND_X, S_SEND_Y: state_d = S_WAIT;
            S_WAIT: begin
                if (!wait_done) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (y_owed_q) begin
                    state_d = S_SEND_Y;
                end else if (!fifo_empty) begin
                    state_d = S_SEND_KEY;
                end else if (mouse_pending_q) begin
                    state_d = S_SEND_X;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: word registers toggle/update together on the send cycle
    always_comb begin
        pop     = (state_q == S_SEND_KEY);
        send_x  = (state_q == S_SEND_X);
        send_y  = (state_q == S_SEND_Y);
        level_d = level_q;
        type_d  = type_q;
        data_d  = data_q;
        if (pop) begin
            level_d = ~level_q;
            type_d  = 2'd2;
            data_d  = mem_q[rd_ptr_q[AW-1:0]];
        end else if (send_x) begin
            level_d = ~level_q;
            type_d  = 2'd0;
            data_d  = acc_x_q;
        end else if (send_y) begin
            level_d = ~level_q;
            type_d  = 2'd1;
            data_d  = snap_y_q;
        end
    end

    // Key FIFO, mouse accumulators and side outputs; a strobe landing in
    // SEND_X starts the fresh accumulation from zero
    always_comb begin
        push       = key_strobe && (!fifo_full || pop);
        overflow_d = key_strobe && fifo_full && !pop;
        mem_d      = mem_q;
        if (push) mem_d[wr_ptr_q[AW-1:0]] = key_code;
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        base_x     = send_x ? 8'h00 : acc_x_q;
        base_y     = send_x ? 8'h00 : acc_y_q;
        acc_x_d    = mouse_strobe ? sat_add(base_x, mouse_dx) : base_x;
        acc_y_d    = mouse_strobe ? sat_add(base_y, mouse_dy) : base_y;
        snap_y_d   = send_x ? acc_y_q : snap_y_q;

        mouse_pending_d = send_x ? 1'b0 : mouse_pending_q;
        if (mouse_strobe && (mouse_dx != 8'h00 || mouse_dy != 8'h00)) mouse_pending_d = 1'b1;

        y_owed_d = y_owed_q;
        if (send_x)      y_owed_d = 1'b1;
        else if (send_y) y_owed_d = 1'b0;

        buttons_d = mouse_btn_in;
    end

    assign kbd_mouse_level = level_q;
    assign kbd_mouse_type  = type_q;
    assign kbd_mouse_data  = data_q;
    assign mouse_buttons   = buttons_q;
    assign key_overflow    = overflow_q;
    assign busy            = (state_q != S_IDLE);
endmodule

// File: tb/tb_kbd_mouse_feeder.sv
// Bench for kbd_mouse_feeder: timeline model of the word scheduler checked
// every cycle, plus literal expectations for each directed scenario.
module tb_kbd_mouse_feeder;
    localparam int GAP   = 16;
    localparam int DEPTH = 8;
    localparam int K_NONE = 0, K_KEY = 1, K_X = 2, K_Y = 3;

    logic       clk_sys = 0, reset = 1;
    logic       key_strobe = 0, mouse_strobe = 0;
    logic [7:0] key_code = 0, mouse_dx = 0, mouse_dy = 0;
    logic [2:0] mouse_btn_in = 0;
    logic       kbd_mouse_level, key_overflow, busy;
    logic [1:0] kbd_mouse_type;
    logic [7:0] kbd_mouse_data;
    logic [2:0] mouse_buttons;

    kbd_mouse_feeder #(.GAP_CYCLES(GAP), .KEY_FIFO_DEPTH(DEPTH)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .key_strobe(key_strobe), .key_code(key_code),
        .mouse_strobe(mouse_strobe), .mouse_dx(mouse_dx), .mouse_dy(mouse_dy),
        .mouse_btn_in(mouse_btn_in),
        .kbd_mouse_level(kbd_mouse_level), .kbd_mouse_type(kbd_mouse_type),
        .kbd_mouse_data(kbd_mouse_data), .mouse_buttons(mouse_buttons),
        .key_overflow(key_overflow), .busy(busy)
    );

    always #5 clk_sys = ~clk_sys;

    int nvec = 0, nmis = 0;
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: FIFO as a queue, accumulators as ints, and one scheduled send
    // cycle `ls`; a new word may be chosen once cycle ls+GAP-1 is reached.
    int  kq[$];
    int  ax, ay, snapy, ls, kind, nk, cyc = 0, ovf_cnt = 0, eb;
    bit  pend, yowed, lsv, prev_level;
    logic       p_level, p_ovf;
    logic [1:0] p_type;
    logic [7:0] p_data;
    logic [2:0] p_btn;
    int  lc[$], lt[$], ld[$];

    function automatic int sat(input int v);
        return (v > 127) ? 127 : (v < -128) ? -128 : v;
    endfunction

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    always @(negedge clk_sys) begin
        cyc++;
        if (reset) begin
            kq.delete(); ax = 0; ay = 0; snapy = 0; pend = 0; yowed = 0;
            lsv = 0; ls = 0; kind = K_NONE; prev_level = 0;
            p_level = 0; p_type = 0; p_data = 0; p_ovf = 0; p_btn = 0;
        end else begin
            if (kbd_mouse_level !== prev_level) begin
                lc.push_back(cyc); lt.push_back(int'(kbd_mouse_type)); ld.push_back(int'(kbd_mouse_data));
                prev_level = kbd_mouse_level;
            end
            if (key_overflow === 1'b1) ovf_cnt++;
        end
        eb = (lsv && cyc >= ls && cyc <= ls + GAP - 1) ? 1 : 0;
        check("level", kbd_mouse_level, p_level);
        check("type", kbd_mouse_type, p_type);
        check("data", kbd_mouse_data, p_data);
        check("overflow", key_overflow, p_ovf);
        check("buttons", mouse_buttons, p_btn);
        check("busy", busy, eb[0]);
        if (!reset) begin
            nk = K_NONE;
            if (!(lsv && cyc == ls) && (!lsv || cyc >= ls + GAP - 1))
                nk = yowed ? K_Y : (kq.size() > 0) ? K_KEY : pend ? K_X : K_NONE;
            p_ovf = 0;
            p_btn = mouse_btn_in;
            if (lsv && cyc == ls) begin
                p_level = ~p_level;
                case (kind)
                    K_KEY: begin p_type = 2; p_data = 8'(kq.pop_front()); end
                    K_X: begin
                        p_type = 0; p_data = 8'(ax);
                        snapy = ay; ax = 0; ay = 0; pend = 0; yowed = 1;
                    end
                    default: begin p_type = 1; p_data = 8'(snapy); yowed = 0; end
                endcase
            end
            if (key_strobe) begin
                if (kq.size() < DEPTH) kq.push_back(int'(key_code));
                else p_ovf = 1;
            end
            if (mouse_strobe) begin
                ax = sat(ax + int'($signed(mouse_dx)));
                ay = sat(ay + int'($signed(mouse_dy)));
                if (mouse_dx != 0 || mouse_dy != 0) pend = 1;
            end
            if (nk != K_NONE) begin ls = cyc + 1; lsv = 1; kind = nk; end
        end
    end

    task automatic tick(); @(posedge clk_sys); #1; endtask
    task automatic idle(input int n); repeat (n) tick(); endtask
    task automatic key(input logic [7:0] c);
        key_strobe = 1; key_code = c; tick(); key_strobe = 0;
    endtask
    task automatic mouse(input int dx, input int dy);
        mouse_strobe = 1; mouse_dx = 8'(dx); mouse_dy = 8'(dy); tick(); mouse_strobe = 0;
    endtask
    task automatic clear_log(); lc.delete(); lt.delete(); ld.delete(); ovf_cnt = 0; endtask
    task automatic check_reset_outputs(input string nm);
        check({nm, "_level"}, kbd_mouse_level, 1'b0);
        check({nm, "_type"}, kbd_mouse_type, 2'd0);
        check({nm, "_data"}, kbd_mouse_data, 8'd0);
        check({nm, "_btn"}, mouse_buttons, 3'd0);
        check({nm, "_ovf"}, key_overflow, 1'b0);
        check({nm, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        mouse_btn_in = 3'b111;
        idle(3);
        check_reset_outputs("rst");
        reset = 0;
        mouse_btn_in = 3'b101;
        tick();
        check("btn_delay", mouse_buttons, 3'b101);
        mouse_btn_in = 3'b010;

        // single key
        clear_log(); key(8'h45); idle(3 * GAP);
        check("k1_count", lt.size(), 1);
        check("k1_type", qget(lt, 0), 2);
        check("k1_data", qget(ld, 0), 32'h45);

        // nine keys into a depth-8 FIFO while the FSM is still waiting
        key(8'h77); idle(3); clear_log();
        for (int i = 1; i <= 9; i++) key(8'(i));
        idle(11 * GAP);
        check("k9_count", lt.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("k9_data%0d", i), qget(ld, i), i + 1);
            if (i > 0) check($sformatf("k9_gap%0d", i), qget(lc, i) - qget(lc, i - 1), GAP);
        end
        check("k9_ovf_pulses", ovf_cnt, 1);

        // saturating X, negative Y
        clear_log(); mouse(100, -3); mouse(100, 0); idle(4 * GAP);
        check("m_count", lt.size(), 2);
        check("m_x", {qget(lt, 0), qget(ld, 0)}, {32'd0, 32'h7F});
        check("m_y", {qget(lt, 1), qget(ld, 1)}, {32'd1, 32'hFD});
        check("m_gap", qget(lc, 1) - qget(lc, 0), GAP);

        // key arriving mid-pair waits for Y
        clear_log(); mouse(3, 4); idle(3); key(8'h20); idle(5 * GAP);
        check("p_types", {qget(lt, 0), qget(lt, 1), qget(lt, 2)}, {32'd0, 32'd1, 32'd2});
        check("p_data", {qget(ld, 0), qget(ld, 1), qget(ld, 2)}, {32'h03, 32'h04, 32'h20});
        check("p_gapxy", qget(lc, 1) - qget(lc, 0), GAP);

        // strobe coinciding with SEND_X
        clear_log(); mouse_btn_in = 3'b100;
        mouse(7, 2); idle(1); mouse(5, 1); idle(6 * GAP);
        check("sx_count", lt.size(), 4);
        check("sx_data", {qget(ld, 0), qget(ld, 1), qget(ld, 2), qget(ld, 3)},
              {32'h07, 32'h02, 32'h05, 32'h01});
        check("sx_gap", qget(lc, 2) - qget(lc, 1), GAP);

        // reset during WAIT with three keys queued
        clear_log();
        for (int i = 1; i <= 4; i++) key(8'(8'h30 + i));
        idle(4);
        reset = 1; tick(); tick();
        check_reset_outputs("mid");
        reset = 0; clear_log(); idle(4 * GAP);
        check("mid_silent", lt.size(), 0);
        key(8'h55); idle(2 * GAP);
        check("mid_after", {lt.size(), qget(ld, 0)}, {32'd1, 32'h55});

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
